// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial unsigned subtractor with start/done handshake
//
// Computes {bout, r} = {1'b0, a} - {1'b0, b} one bit per clock, LSB first.
// Optional build macro: SERIAL_SUB_FLAGS_EN adds zero/ovf result flags.
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      asynchronous reset, active-high
//   start  in   1      request; a/b sampled on the accepting edge (IDLE or DONE)
//   a      in   WIDTH  minuend (unsigned)
//   b      in   WIDTH  subtrahend (unsigned)
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse, r/bout valid from this cycle on
//   r      out  WIDTH  difference modulo 2^WIDTH
//   bout   out  1      borrow out, 1 iff a < b
//   zero   out  1      (SERIAL_SUB_FLAGS_EN) r == 0
//   ovf    out  1      (SERIAL_SUB_FLAGS_EN) signed overflow of a - b

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_brw;
  logic [WIDTH-1:0] w_res;
  logic             w_busy_d;
  logic             w_done_d;

  // start is only honoured outside RUN; this is what makes back-to-back work from DONE.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  // One full-subtractor bit on the current LSBs of the operand shift registers.
  assign w_d   = r_a[0] ^ r_b[0] ^ r_brw;
  assign w_brw = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);

  // Difference bits enter at the MSB, so after WIDTH shifts bit 0 is in place.
  assign w_res = {w_d, r_res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_RUN : S_IDLE;
      S_RUN:   w_next = w_last ? S_DONE : S_RUN;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode, taken from the next state so busy/done can be registered
  // and still line up exactly with RUN/DONE.
  always_comb begin
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    case (w_next)
      S_RUN:   w_busy_d = 1'b1;
      S_DONE:  w_done_d = 1'b1;
      default: begin
        w_busy_d = 1'b0;
        w_done_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= w_busy_d;
      done <= w_done_d;
    end
  end

  // Serial datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_brw <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_brw <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= {1'b0, r_a[WIDTH-1:1]};
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_res <= w_res;
      r_brw <= w_brw;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Result registers load on the edge that enters DONE, directly from the
  // final bit's combinational value, so they hold the old result during RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r    <= '0;
      bout <= 1'b0;
    end else if (w_last) begin
      r    <= w_res;
      bout <= w_brw;
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // On the last RUN edge the operand LSBs are the original MSBs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (w_last) begin
      zero <= (w_res == '0);
      ovf  <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
    end
  end
`endif

endmodule
